// File: rtl/text_write_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// text_write_ctrl_pkg
// Shared constants for the text-mode write controller: screen geometry,
// erase code, UART control codes and the controller state encoding.
// ---------------------------------------------------------------------------
package text_write_ctrl_pkg;

    localparam int          TXT_COLS  = 80;
    localparam int          TXT_ROWS  = 30;
    localparam logic [6:0]  TXT_BLANK = 7'h20;

    localparam int          XW = 7;   // column field width in waddr
    localparam int          YW = 5;   // row field width in waddr

    localparam logic [6:0]  CODE_BS  = 7'h08;
    localparam logic [6:0]  CODE_LF  = 7'h0A;
    localparam logic [6:0]  CODE_FF  = 7'h0C;
    localparam logic [6:0]  CODE_CR  = 7'h0D;
    localparam logic [6:0]  PRINT_LO = 7'h20;
    localparam logic [6:0]  PRINT_HI = 7'h7E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= PRINT_LO) && (code <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_write_ctrl_cursor_step.sv
// ---------------------------------------------------------------------------
// cursor_step
// Combinational column/row advance with wrap. Shared by the visible cursor
// and by the screen-clear address counters.
//   x_i, y_i     : current column / row
//   step_x_i     : advance column (COLS-1 wraps to 0)
//   step_y_i     : advance row unconditionally (ROWS-1 wraps to 0)
//   carry_i      : advance row when the column wraps
//   x_o, y_o     : next column / row
// ---------------------------------------------------------------------------
module cursor_step
    import text_write_ctrl_pkg::*;
#(
    parameter int COLS = TXT_COLS,
    parameter int ROWS = TXT_ROWS
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic          step_x_i,
    input  logic          step_y_i,
    input  logic          carry_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o
);

    logic x_wrap;

    always_comb begin
        x_wrap = step_x_i && (x_i == XW'(COLS - 1));
        x_o    = x_i;
        if (step_x_i) begin
            x_o = x_wrap ? '0 : x_i + XW'(1);
        end
        // step_y_i and a carry never need to stack: one row per call at most
        y_o = y_i;
        if (step_y_i || (carry_i && x_wrap)) begin
            y_o = (y_i == YW'(ROWS - 1)) ? '0 : y_i + YW'(1);
        end
    end

endmodule

// File: rtl/text_write_ctrl.sv
// ---------------------------------------------------------------------------
// text_write_ctrl
// Consumes bytes from a UART receive FIFO and writes them into a text tile
// RAM at the cursor, handling CR/LF/BS/FF control codes, cursor keys and a
// full-screen clear.
//   clk, rst_n            : clock, async active-low reset
//   rx_empty, rx_data     : FIFO status and head byte
//   rd_uart               : one-cycle FIFO pop strobe
//   key_right, key_down   : cursor movement ticks
//   clr_req               : clear-screen tick
//   we, waddr, wdata      : tile RAM write port, waddr = {row, col}
//   cur_x, cur_y          : cursor position
//   busy                  : high while the screen is being cleared
// ---------------------------------------------------------------------------
module text_write_ctrl
    import text_write_ctrl_pkg::*;
#(
    parameter int         COLS  = TXT_COLS,
    parameter int         ROWS  = TXT_ROWS,
    parameter logic [6:0] BLANK = TXT_BLANK
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_empty,
    input  logic [7:0]           rx_data,
    output logic                 rd_uart,
    input  logic                 key_right,
    input  logic                 key_down,
    input  logic                 clr_req,
    output logic                 we,
    output logic [XW+YW-1:0]     waddr,
    output logic [6:0]           wdata,
    output logic [XW-1:0]        cur_x,
    output logic [YW-1:0]        cur_y,
    output logic                 busy
);

    state_e              state_q;
    logic [XW-1:0]       cur_x_q, clr_x_q;
    logic [YW-1:0]       cur_y_q, clr_y_q;
    logic [6:0]          cmd_q;
    logic                we_q, rd_q, busy_q;
    logic [XW+YW-1:0]    waddr_q;
    logic [6:0]          wdata_q;

    logic                cs_step_x, cs_step_y, cs_carry;
    logic [XW-1:0]       cur_x_d, clr_x_d;
    logic [YW-1:0]       cur_y_d, clr_y_d;
    logic                clr_last;

    logic                unused_rx_msb;
    assign unused_rx_msb = rx_data[7];

    // Cursor step controls depend on which path is moving the cursor.
    always_comb begin
        cs_step_x = 1'b0;
        cs_step_y = 1'b0;
        cs_carry  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!clr_req && rx_empty) begin
                    cs_step_x = key_right;
                    cs_step_y = key_down;
                end
            end
            ST_EXEC: begin
                if (is_printable(cmd_q)) begin
                    cs_step_x = 1'b1;
                    cs_carry  = 1'b1;
                end else if (cmd_q == CODE_LF) begin
                    cs_step_y = 1'b1;
                end
            end
            default: ;
        endcase
    end

    cursor_step #(.COLS(COLS), .ROWS(ROWS)) u_cur_step (
        .x_i      (cur_x_q),
        .y_i      (cur_y_q),
        .step_x_i (cs_step_x),
        .step_y_i (cs_step_y),
        .carry_i  (cs_carry),
        .x_o      (cur_x_d),
        .y_o      (cur_y_d)
    );

    cursor_step #(.COLS(COLS), .ROWS(ROWS)) u_clr_step (
        .x_i      (clr_x_q),
        .y_i      (clr_y_q),
        .step_x_i (1'b1),
        .step_y_i (1'b0),
        .carry_i  (1'b1),
        .x_o      (clr_x_d),
        .y_o      (clr_y_d)
    );

    assign clr_last = (clr_x_q == XW'(COLS - 1)) && (clr_y_q == YW'(ROWS - 1));

    // The clear counters always hold the cell being written this cycle; the
    // write for cell {0,0} is launched on the transition into CLEAR so that
    // we/busy line up exactly with the CLEAR state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_x_q <= '0;
            cur_y_q <= '0;
            clr_x_q <= '0;
            clr_y_q <= '0;
            cmd_q   <= '0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q   <= 1'b0;
            rd_q   <= 1'b0;
            busy_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        waddr_q <= '0;
                        wdata_q <= BLANK;
                    end else if (!rx_empty) begin
                        rd_q    <= 1'b1;
                        cmd_q   <= rx_data[6:0];
                        state_q <= ST_EXEC;
                    end else begin
                        cur_x_q <= cur_x_d;
                        cur_y_q <= cur_y_d;
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_IDLE;
                    if (is_printable(cmd_q)) begin
                        we_q    <= 1'b1;
                        waddr_q <= {cur_y_q, cur_x_q};
                        wdata_q <= cmd_q;
                        cur_x_q <= cur_x_d;
                        cur_y_q <= cur_y_d;
                    end else begin
                        case (cmd_q)
                            CODE_CR: cur_x_q <= '0;
                            CODE_LF: begin
                                cur_x_q <= '0;
                                cur_y_q <= cur_y_d;
                            end
                            CODE_BS: begin
                                if (cur_x_q != '0) begin
                                    we_q    <= 1'b1;
                                    waddr_q <= {cur_y_q, cur_x_q - XW'(1)};
                                    wdata_q <= BLANK;
                                    cur_x_q <= cur_x_q - XW'(1);
                                end
                            end
                            CODE_FF: begin
                                state_q <= ST_CLEAR;
                                we_q    <= 1'b1;
                                busy_q  <= 1'b1;
                                waddr_q <= '0;
                                wdata_q <= BLANK;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    if (clr_last) begin
                        state_q <= ST_IDLE;
                        clr_x_q <= '0;
                        clr_y_q <= '0;
                        cur_x_q <= '0;
                        cur_y_q <= '0;
                    end else begin
                        clr_x_q <= clr_x_d;
                        clr_y_q <= clr_y_d;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        waddr_q <= {clr_y_d, clr_x_d};
                        wdata_q <= BLANK;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign we      = we_q;
    assign rd_uart = rd_q;
    assign busy    = busy_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign cur_x   = cur_x_q;
    assign cur_y   = cur_y_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_text_write_ctrl
// Scoreboard bench: stimulus pushes expected tile-RAM writes into a queue,
// a monitor pops and compares on every we cycle. A small FIFO model feeds
// rx_empty/rx_data and pops on rd_uart.
// ---------------------------------------------------------------------------
module tb_text_write_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        key_right = 1'b0;
    logic        key_down = 1'b0;
    logic        clr_req = 1'b0;
    logic        rd_uart, we, busy;
    logic [11:0] waddr;
    logic [6:0]  wdata;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;

    logic [7:0]  fifo[$];
    logic [18:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          rd_busy = 0;
    int          n_pushed = 0;

    text_write_ctrl #(.COLS(80), .ROWS(30), .BLANK(7'h20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_empty  (rx_empty),
        .rx_data   (rx_data),
        .rd_uart   (rd_uart),
        .key_right (key_right),
        .key_down  (key_down),
        .clr_req   (clr_req),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .busy      (busy)
    );

    always #20 clk = ~clk;

    function automatic logic [11:0] addr_of(input int y, input int x);
        return {5'(y), 7'(x)};
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [11:0] a, input logic [6:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_blanks(input int n);
        for (int i = 0; i < n; i++) push_exp(addr_of(i / 80, i % 80), 7'h20);
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        n_pushed++;
        rx_empty = 1'b0;
        rx_data  = fifo[0];
    endtask

    task automatic pulse_keys(input logic r, input logic d);
        key_right = r;
        key_down  = d;
        @(negedge clk);
        key_right = 1'b0;
        key_down  = 1'b0;
    endtask

    task automatic move(input int rights, input int downs);
        for (int i = 0; i < rights; i++) pulse_keys(1'b1, 1'b0);
        for (int i = 0; i < downs; i++) pulse_keys(1'b0, 1'b1);
    endtask

    task automatic check_cur(input string name, input int x, input int y);
        check({name, "_x"}, int'(cur_x), x);
        check({name, "_y"}, int'(cur_y), y);
    endtask

    // Wait until the FIFO is drained and no clear runs, then settle.
    task automatic drain();
        int t = 0;
        while ((fifo.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            errors++;
            $display("FAIL drain_timeout: fifo=%0d busy=%0b", fifo.size(), busy);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rd(output logic seen);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (rd_uart) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL rd_timeout: rd_uart never asserted");
        end
    endtask

    task automatic count_busy(output int n);
        int t = 0;
        n = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        while (busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // FIFO model: pops away from the active edge so the DUT sees a stable head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rd_uart && fifo.size() > 0) begin
                fifo.delete(0);
                rx_empty = (fifo.size() == 0);
                rx_data  = (fifo.size() == 0) ? 8'h00 : fifo[0];
            end
        end
    end

    // Monitor: every write must match the head of the scoreboard.
    initial begin
        logic [18:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rd_uart) rd_cnt++;
                if (rd_uart && busy) rd_busy++;
                if (we) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr 0x%03h data 0x%02h, none expected", waddr, wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({waddr, wdata} != e) begin
                            errors++;
                            $display("FAIL write: addr 0x%03h data 0x%02h expected addr 0x%03h data 0x%02h",
                                     waddr, wdata, e[18:7], e[6:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic seen;
        int   n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_we", int'(we), 0);
        check("rst_rd", int'(rd_uart), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_wdata", int'(wdata), 0);
        check_cur("rst_cur", 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 'A' at {0,0}; write lands the cycle after the pop strobe
        push_exp(12'h000, 7'h41);
        push_byte(8'h41);
        wait_rd(seen);
        @(negedge clk);
        check("a_we_after_rd", int'(we), 1);
        check("a_rd_single", int'(rd_uart), 0);
        drain();
        check_cur("a_cur", 1, 0);
        check("a_rd_cnt", rd_cnt, 1);

        // Bottom-right write wraps the cursor to origin
        move(78, 29);
        check_cur("br_cur", 79, 29);
        push_exp(12'hECF, 7'h42);
        push_byte(8'h42);
        drain();
        check_cur("br_wrap", 0, 0);

        // Simultaneous keys at the corner, then right wrap without row carry
        move(79, 29);
        pulse_keys(1'b1, 1'b1);
        check_cur("keys_both", 0, 0);
        move(80, 0);
        check_cur("right_nocarry", 0, 0);

        // Backspace then line feed from (5,3)
        move(5, 3);
        push_exp(addr_of(3, 4), 7'h20);
        push_byte(8'h08);
        drain();
        check_cur("bs", 4, 3);
        push_byte(8'h0A);
        drain();
        check_cur("lf", 0, 4);

        // Backspace at column 0, carriage return, ignored code
        push_byte(8'h08);
        drain();
        check_cur("bs_col0", 0, 4);
        move(3, 0);
        push_byte(8'h0D);
        drain();
        check_cur("cr", 0, 4);
        push_byte(8'h01);
        drain();
        check_cur("ignored", 0, 4);

        // Key tick during EXEC, and key tick in the popping IDLE cycle
        push_byte(8'h01);
        wait_rd(seen);
        pulse_keys(1'b1, 1'b0);
        drain();
        check_cur("key_in_exec", 0, 4);
        push_byte(8'h01);
        pulse_keys(1'b0, 1'b1);
        drain();
        check_cur("key_in_pop", 0, 4);

        // clr_req with a byte waiting: clear wins, byte is kept for afterwards
        push_blanks(2400);
        push_exp(12'h000, 7'h43);
        n = rd_cnt;
        push_byte(8'h43);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        count_busy(n);
        check("clr_busy_cycles", n, 2400);
        check("clr_rd_during_busy", rd_busy, 0);
        drain();
        check_cur("clr_then_byte", 1, 0);

        // Form feed over UART, then printable/non-printable boundaries
        push_blanks(2400);
        push_byte(8'h0C);
        count_busy(n);
        check("ff_busy_cycles", n, 2400);
        repeat (2) @(negedge clk);
        check_cur("ff_cur", 0, 0);
        push_exp(12'h000, 7'h7E);
        push_byte(8'h7E);
        push_byte(8'h7F);
        drain();
        check_cur("hi_bound", 1, 0);

        // Reset in the middle of a clear aborts it for good
        push_blanks(1000);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (999) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we", int'(we), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rd", int'(rd_uart), 0);
        check("midrst_waddr", int'(waddr), 0);
        check("midrst_wdata", int'(wdata), 0);
        check_cur("midrst_cur", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check_cur("post_rst_cur", 0, 0);

        check("sb_empty", exp_q.size(), 0);
        check("rd_total", rd_cnt, n_pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/text_write_ctrl.md
TEXT_WRITE_CTRL -- requirements
Module: text_write_ctrl

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 Parameter BLANK, default 7'h20, code written to erase a cell.
REQ-004 clk  in  1  system clock (25 MHz pixel clock domain); the block has one clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rx_empty  in  1  UART receive FIFO empty flag.
REQ-007 rx_data  in  8  UART FIFO head byte, valid whenever rx_empty=0.
REQ-008 rd_uart  out  1  one-cycle FIFO pop strobe.
REQ-009 key_right  in  1  debounced one-cycle tick: cursor right.
REQ-010 key_down  in  1  debounced one-cycle tick: cursor down.
REQ-011 clr_req  in  1  one-cycle tick: clear the screen.
REQ-012 we  out  1  tile-RAM write enable.
REQ-013 waddr  out  12  tile-RAM write address {row[4:0], col[6:0]}.
REQ-014 wdata  out  7  tile-RAM write data (ASCII code).
REQ-015 cur_x  out  7  cursor column, for the underline overlay.
REQ-016 cur_y  out  5  cursor row, for the underline overlay.
REQ-017 busy  out  1  high while in CLEAR.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC and CLEAR.
REQ-019 In IDLE, clr_req SHALL move the FSM to CLEAR; clr_req takes priority over rx and key ticks in the same cycle.
REQ-020 Otherwise in IDLE, when rx_empty=0, the block SHALL assert rd_uart for exactly one cycle, latch rx_data[6:0] into a command register, and move to EXEC.
REQ-021 In IDLE with no rx and no clear pending, key_right SHALL advance cur_x and key_down SHALL advance cur_y, each with wrap (79->0, 29->0); key_right has no row carry.
REQ-022 If key_right and key_down arrive in the same cycle, both SHALL be applied.
REQ-023 Key ticks that arrive in EXEC or CLEAR, or in an IDLE cycle that pops the FIFO, SHALL be dropped.
REQ-024 EXEC SHALL last one cycle and then return to IDLE, so one byte is consumed at most every 2 cycles.
REQ-025 EXEC, printable code (0x20-0x7E): assert we with waddr={cur_y,cur_x} and wdata=code, then advance the cursor: x+1, or x=0 and y+1 (29->0) when x=79.
REQ-026 EXEC, 0x0D: set cur_x=0 with no write.
REQ-027 EXEC, 0x0A: set cur_x=0 and cur_y=y+1 (29->0) with no write.
REQ-028 EXEC, 0x08 with cur_x>0: write BLANK at {cur_y,cur_x-1} and decrement cur_x.
REQ-029 EXEC, 0x08 with cur_x=0: no write and no cursor move.
REQ-030 EXEC, 0x0C: no write; the FSM SHALL go to CLEAR instead of IDLE.
REQ-031 EXEC, any other code: ignore it and return to IDLE.
REQ-032 CLEAR SHALL write BLANK to every cell with we=1, one cell per cycle, in row-major order from {0,0} to {29,79}: 2400 consecutive cycles.
REQ-033 On the cycle after the last CLEAR write, cur_x and cur_y SHALL be 0 and the FSM SHALL be in IDLE.
REQ-034 During CLEAR, rd_uart SHALL stay 0, so FIFO contents are preserved, and clr_req SHALL be ignored.
REQ-035 we, rd_uart and busy SHALL be registered outputs; waddr and wdata SHALL be valid in the same cycle as we.
REQ-036 Column and row counters SHALL never hold values >=COLS or >=ROWS, respectively.

Reset
REQ-037 On rst_n=0 the block SHALL asynchronously set: state=IDLE; cur_x=0, cur_y=0; we=0, rd_uart=0, busy=0; waddr=0, wdata=0; clear counters=0.
REQ-038 Reset mid-CLEAR SHALL abort the clear; the block does not resume it.

Structure
REQ-039 A shared package SHALL hold COLS, ROWS, BLANK, the control codes (0x08, 0x0A, 0x0C, 0x0D) and the state encoding.
REQ-040 Cursor advance/wrap logic SHALL be one sub-module, cursor_step, reused by the cursor path and the CLEAR counters.

Verification
REQ-041 Reset, FIFO holds 'A' (0x41) -> rd_uart pulses once; next cycle we=1, waddr=0x000, wdata=0x41; then cur_x=1.
REQ-042 Cursor at (79,29), byte 0x42 -> write at waddr={29,79}=0xECF; cursor wraps to (0,0).
REQ-043 Cursor at (5,3), bytes 0x08 then 0x0A -> BLANK written at {3,4}; cur_x=4, then cur_x=0, cur_y=4.
REQ-044 clr_req with 0x43 waiting in the FIFO -> busy high for 2400 cycles, 2400 BLANK writes, no rd_uart; afterwards 0x43 is written at {0,0}.
REQ-045 rst_n low at CLEAR cycle 1000 -> all outputs 0 immediately; after release, IDLE with no writes.
REQ-046 key_right and key_down in the same IDLE cycle at (79,29) -> (0,0); key tick during EXEC -> cursor unaffected by the key.
